// File: rtl/mem_interface_pkg.sv
// Shared constants and helpers for the memory-side stage: MMIO offsets,
// status bit positions and the access-type decode.
package mem_interface_pkg;

  localparam logic [7:0] MMIO_TX     = 8'h00;
  localparam logic [7:0] MMIO_STATUS = 8'h01;
  localparam logic [7:0] MMIO_RX     = 8'h02;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_RXV   = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  function automatic logic [7:0] status_byte(input logic full, input logic empty,
                                             input logic rxv, input logic ovf);
    logic [7:0] s;
    s = '0;
    s[STAT_FULL]  = full;
    s[STAT_EMPTY] = empty;
    s[STAT_RXV]   = rxv;
    s[STAT_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/mem_interface_if.sv
// Bus bundle between the control FSM / RAM / serial side and the memory stage.
interface mem_interface_if;
  logic [15:0] addr_bus_in;
  logic [7:0]  data_bus_in;
  logic        address_read;
  logic        data_in;
  logic        data_out;
  logic        mem_enable;
  logic [7:0]  data_bus_out;
  logic        data_bus_oe;
  logic [15:0] ram_addr;
  logic        ram_re;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport slave (
    input  addr_bus_in, data_bus_in, address_read, data_in, data_out, mem_enable,
           ram_rdata, tx_ready, rx_data, rx_valid,
    output data_bus_out, data_bus_oe, ram_addr, ram_re, ram_we, ram_wdata,
           tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr_bus_in, data_bus_in, address_read, data_in, data_out, mem_enable,
           ram_rdata, tx_ready, rx_data, rx_valid,
    input  data_bus_out, data_bus_oe, ram_addr, ram_re, ram_we, ram_wdata,
           tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/mem_interface_tx_fifo.sv
// Transmit FIFO: circular buffer with occupancy counter; a push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [7:0]    mem [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_interface.sv
// Memory-side stage: address latch, two-cycle reads / single-cycle writes to a
// synchronous RAM, and an MMIO window with TX FIFO, RX holding register, status.
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int          TX_DEPTH  = 4,
  parameter logic [15:0] MMIO_BASE = 16'hFF00
) (
  input  logic           clk,
  input  logic           rst,
  mem_interface_if.slave bus
);

  logic [15:0] addr_q;
  logic        read_pending;
  logic        overflow;
  logic        rx_hold_valid;
  logic [7:0]  rx_hold;
  acc_e        acc;
  logic        mmio;
  logic [7:0]  offset;
  logic        rd_done;
  logic        push, pop_fire;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_head;
  logic [7:0]  mmio_rdata;
  logic        stat_clr, rx_clr, rx_cap;

  // Both transfer strobes together is treated as no access at all.
  always_comb begin
    acc = ACC_NONE;
    if (bus.mem_enable && bus.data_in && !bus.data_out)      acc = ACC_READ;
    else if (bus.mem_enable && bus.data_out && !bus.data_in) acc = ACC_WRITE;
  end

  assign mmio    = (addr_q >= MMIO_BASE);
  assign offset  = addr_q[7:0];
  assign rd_done = (acc == ACC_READ) && read_pending;

  always_comb begin
    mmio_rdata = 8'h00;
    case (offset)
      MMIO_STATUS: mmio_rdata = status_byte(fifo_full, fifo_empty, rx_hold_valid, overflow);
      MMIO_RX:     mmio_rdata = rx_hold;
      default:     mmio_rdata = 8'h00;
    endcase
  end

  assign bus.ram_addr     = addr_q;
  assign bus.ram_re       = (acc == ACC_READ) && !read_pending && !mmio;
  assign bus.ram_we       = (acc == ACC_WRITE) && !mmio;
  assign bus.ram_wdata    = bus.ram_we ? bus.data_bus_in : 8'h00;
  assign bus.data_bus_oe  = rd_done;
  assign bus.data_bus_out = !rd_done ? 8'h00 : (mmio ? mmio_rdata : bus.ram_rdata);

  assign push     = (acc == ACC_WRITE) && mmio && (offset == MMIO_TX);
  assign pop_fire = !fifo_empty && bus.tx_ready;
  assign stat_clr = rd_done && mmio && (offset == MMIO_STATUS);
  assign rx_clr   = rd_done && mmio && (offset == MMIO_RX);
  assign rx_cap   = bus.rx_valid && !rx_hold_valid;

  assign bus.tx_data  = fifo_head;
  assign bus.tx_valid = !fifo_empty;
  assign bus.rx_ready = !rx_hold_valid;

  tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (bus.tx_ready),
    .wdata (bus.data_bus_in),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A third back-to-back read cycle sees read_pending clear and restarts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      read_pending  <= 1'b0;
      overflow      <= 1'b0;
      rx_hold_valid <= 1'b0;
    end else begin
      if (bus.address_read) addr_q <= bus.addr_bus_in;
      read_pending <= (acc == ACC_READ) && !read_pending;
      if (push && fifo_full && !pop_fire) overflow <= 1'b1;
      else if (stat_clr)                  overflow <= 1'b0;
      if (rx_cap)      rx_hold_valid <= 1'b1;
      else if (rx_clr) rx_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_cap) rx_hold <= bus.rx_data;
  end

endmodule

// File: tb/tb_mem_interface.sv
// Bench for mem_interface: directed scenarios plus random cycles, every cycle
// compared against a queue/array reference model of the memory stage.
module tb_mem_interface;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  mem_interface_if bus();

  mem_interface #(.TX_DEPTH(DEPTH), .MMIO_BASE(16'hFF00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram_mem [65536];
  always @(posedge clk) begin
    if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0]  ref_mem [65536];
  logic [15:0] m_addr;
  int          m_rdrun;
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic        m_rxv;
  logic [7:0]  m_rxb;

  logic [7:0] o_dout, o_txd;
  logic       o_oe, o_re, o_we, o_txv, o_rxr;
  logic [7:0] rd_val;
  logic [7:0] exp_drain1 [4];
  logic [7:0] exp_drain2 [4];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_addr  = 16'h0000;
    m_rdrun = 0;
    m_q.delete();
    m_ovf   = 1'b0;
    m_rxv   = 1'b0;
  endtask

  // One clock cycle: inputs already applied; compare at negedge, advance model.
  task automatic cycle();
    logic       rd, wr, mmio, cyc2, pop, push, exp_re, exp_we;
    logic [7:0] off, exp_dout;
    int         status;
    @(negedge clk);
    rd   = bus.mem_enable && bus.data_in && !bus.data_out;
    wr   = bus.mem_enable && bus.data_out && !bus.data_in;
    mmio = (m_addr >= 16'hFF00);
    off  = m_addr[7:0];
    cyc2 = rd && (m_rdrun % 2 == 1);
    exp_re = rd && !cyc2 && !mmio;
    exp_we = wr && !mmio;
    status = (m_ovf ? 8 : 0) + (m_rxv ? 4 : 0) + (m_q.size() == 0 ? 2 : 0)
           + (m_q.size() == DEPTH ? 1 : 0);
    exp_dout = 8'h00;
    if (cyc2) begin
      if (!mmio)           exp_dout = ref_mem[m_addr];
      else if (off == 8'd1) exp_dout = 8'(status);
      else if (off == 8'd2) exp_dout = m_rxb;
    end
    o_dout = bus.data_bus_out; o_oe = bus.data_bus_oe; o_re = bus.ram_re;
    o_we = bus.ram_we; o_txd = bus.tx_data; o_txv = bus.tx_valid; o_rxr = bus.rx_ready;
    check("ram_addr", bus.ram_addr, m_addr);
    check("ram_re", 16'(o_re), 16'(exp_re));
    check("data_bus_oe", 16'(o_oe), 16'(cyc2));
    check("data_bus_out", 16'(o_dout), 16'(exp_dout));
    check("ram_we", 16'(o_we), 16'(exp_we));
    if (exp_we) check("ram_wdata", 16'(bus.ram_wdata), 16'(bus.data_bus_in));
    check("tx_valid", 16'(o_txv), 16'(m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", 16'(o_txd), 16'(m_q[0]));
    check("rx_ready", 16'(o_rxr), 16'(!m_rxv));
    // Advance the model to the state after this edge
    pop  = (m_q.size() != 0) && bus.tx_ready;
    push = wr && mmio && (off == 8'h00);
    if (push && m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push && m_q.size() < DEPTH) m_q.push_back(bus.data_bus_in);
    if (cyc2 && mmio && off == 8'd1) m_ovf = 1'b0;
    if (bus.rx_valid && !m_rxv) begin
      m_rxv = 1'b1;
      m_rxb = bus.rx_data;
    end else if (cyc2 && mmio && off == 8'd2) begin
      m_rxv = 1'b0;
    end
    if (exp_we) ref_mem[m_addr] = bus.data_bus_in;
    m_rdrun = rd ? m_rdrun + 1 : 0;
    if (bus.address_read) m_addr = bus.addr_bus_in;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [15:0] a);
    bus.address_read = 1'b1;
    bus.addr_bus_in  = a;
    cycle();
    bus.address_read = 1'b0;
  endtask

  task automatic wr1(input logic [7:0] d);
    bus.mem_enable = 1'b1; bus.data_out = 1'b1; bus.data_bus_in = d;
    cycle();
    bus.mem_enable = 1'b0; bus.data_out = 1'b0;
  endtask

  task automatic rd2(output logic [7:0] d);
    bus.mem_enable = 1'b1; bus.data_in = 1'b1;
    cycle();
    cycle();
    d = o_dout;
    bus.mem_enable = 1'b0; bus.data_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    exp_drain1 = '{8'h01, 8'h02, 8'h03, 8'h04};
    exp_drain2 = '{8'h22, 8'h33, 8'h44, 8'h77};
    bus.addr_bus_in = '0; bus.data_bus_in = '0; bus.address_read = 1'b0;
    bus.data_in = 1'b0; bus.data_out = 1'b0; bus.mem_enable = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_data = '0; bus.rx_valid = 1'b0;
    m_rxb = 8'h00;
    model_reset();

    // Reset state
    rst = 1'b1;
    #2;
    check("rst_oe", 16'(bus.data_bus_oe), 16'd0);
    check("rst_dout", 16'(bus.data_bus_out), 16'd0);
    check("rst_ram_addr", bus.ram_addr, 16'h0000);
    check("rst_tx_valid", 16'(bus.tx_valid), 16'd0);
    check("rst_rx_ready", 16'(bus.rx_ready), 16'd1);
    check("rst_strobes", 16'({bus.ram_re, bus.ram_we}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Preload the RAM locations the bench reads back
    for (int i = 0; i < 16; i++) begin
      set_addr(16'(i));
      wr1(8'($urandom));
    end
    set_addr(16'h1234);
    wr1(8'hA5);

    // RAM read
    set_addr(16'h1234);
    bus.mem_enable = 1'b1; bus.data_in = 1'b1;
    cycle();
    check("rd_c1_re", 16'(o_re), 16'd1);
    check("rd_c1_oe", 16'(o_oe), 16'd0);
    cycle();
    check("rd_c2_re", 16'(o_re), 16'd0);
    check("rd_c2_oe", 16'(o_oe), 16'd1);
    check("rd_c2_data", 16'(o_dout), 16'h00A5);
    bus.mem_enable = 1'b0; bus.data_in = 1'b0;
    cycle();
    check("rd_after_oe", 16'(o_oe), 16'd0);

    // RAM write, then ignored write into MMIO space
    set_addr(16'h0040);
    wr1(8'h3C);
    check("wr_we", 16'(o_we), 16'd1);
    cycle();
    check("wr_after_we", 16'(o_we), 16'd0);
    set_addr(16'hFF05);
    wr1(8'h99);
    check("wr_mmio_we", 16'(o_we), 16'd0);

    // FIFO fill past full with the sink stalled
    bus.tx_ready = 1'b0;
    set_addr(16'hFF00);
    for (int i = 1; i <= 5; i++) begin
      wr1(8'(i));
      if (i > 1) check("fill_head", 16'(o_txd), 16'h0001);
    end
    set_addr(16'hFF01);
    rd2(rd_val);
    check("stat_ovf_full", 16'(rd_val), 16'h0009);
    rd2(rd_val);
    check("stat_full", 16'(rd_val), 16'h0001);

    // Drain, then pop-on-full with a simultaneous push
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("drain1", 16'(o_txd), 16'(exp_drain1[i]));
    end
    bus.tx_ready = 1'b0;
    rd2(rd_val);
    check("stat_empty", 16'(rd_val), 16'h0002);
    set_addr(16'hFF00);
    wr1(8'h11); wr1(8'h22); wr1(8'h33); wr1(8'h44);
    bus.tx_ready = 1'b1;
    wr1(8'h77);
    check("popfull_head", 16'(o_txd), 16'h0011);
    bus.tx_ready = 1'b0;
    set_addr(16'hFF01);
    rd2(rd_val);
    check("stat_still_full", 16'(rd_val), 16'h0001);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("drain2", 16'(o_txd), 16'(exp_drain2[i]));
    end
    bus.tx_ready = 1'b0;

    // Receive path
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    cycle();
    bus.rx_valid = 1'b0;
    cycle();
    check("rx_ready_low", 16'(o_rxr), 16'd0);
    set_addr(16'hFF02);
    bus.mem_enable = 1'b1; bus.data_in = 1'b1;
    cycle();
    bus.rx_valid = 1'b1; bus.rx_data = 8'hC3;
    cycle();
    check("rx_read", 16'(o_dout), 16'h005A);
    bus.mem_enable = 1'b0; bus.data_in = 1'b0;
    cycle();
    check("rx_ready_rise", 16'(o_rxr), 16'd1);
    bus.rx_valid = 1'b0;
    cycle();
    check("rx_reheld", 16'(o_rxr), 16'd0);
    rd2(rd_val);
    check("rx_read2", 16'(rd_val), 16'h00C3);

    // Random cycles against the model
    for (int n = 0; n < 600; n++) begin
      bus.mem_enable  = ($urandom_range(0, 3) != 0);
      bus.data_in     = ($urandom_range(0, 2) != 0);
      bus.data_out    = ($urandom_range(0, 2) == 0);
      bus.address_read = !(bus.mem_enable && bus.data_in) && ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       bus.addr_bus_in = 16'(16'hFF00 + $urandom_range(0, 3));
        1:       bus.addr_bus_in = 16'h1234;
        default: bus.addr_bus_in = 16'($urandom_range(0, 15));
      endcase
      bus.data_bus_in = 8'($urandom);
      bus.tx_ready    = ($urandom_range(0, 2) == 0);
      bus.rx_valid    = ($urandom_range(0, 2) == 0);
      bus.rx_data     = 8'($urandom);
      cycle();
    end
    bus.mem_enable = 1'b0; bus.data_in = 1'b0; bus.data_out = 1'b0;
    bus.address_read = 1'b0; bus.tx_ready = 1'b0; bus.rx_valid = 1'b0;
    cycle();

    // Asynchronous reset between the two read cycles
    set_addr(16'h0003);
    bus.mem_enable = 1'b1; bus.data_in = 1'b1;
    cycle();
    rst = 1'b1;
    #1;
    check("arst_oe", 16'(bus.data_bus_oe), 16'd0);
    check("arst_dout", 16'(bus.data_bus_out), 16'd0);
    check("arst_addr", bus.ram_addr, 16'h0000);
    bus.mem_enable = 1'b0; bus.data_in = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    cycle();
    check("arst_idle_oe", 16'(o_oe), 16'd0);
    rd2(rd_val);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_interface.md
Name: mem_interface

Overview:
- Memory-side stage driven directly by the control FSM's address_read / data_in / data_out / mem_enable strobes.
- Latches the 16-bit address from the address bus and runs reads and writes against a synchronous-read RAM.
- Returns read data onto the 8-bit data bus.
- Decodes a small MMIO window containing a transmit FIFO, a receive holding register and a status register.

Parameters:
TX_DEPTH, 4, transmit FIFO entries; power of two, at least 2
MMIO_BASE, 16'hFF00, base of the 256-byte MMIO window; RAM is not accessed at or above this address

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
addr_bus_in  in  16  shared address bus (ALU-mem / mp16 / pc output)
data_bus_in  in  8  shared data bus value driven by registers
address_read  in  1  latch addr_bus_in into the address register
data_in  in  1  memory-to-bus transfer cycle
data_out  in  1  bus-to-memory transfer cycle
mem_enable  in  1  qualifies data_in / data_out
data_bus_out  out  8  read data driven to the bus
data_bus_oe  out  1  data_bus_out is valid this cycle
ram_addr  out  16  RAM address (equals the address register)
ram_re  out  1  RAM read strobe; data appears on ram_rdata next cycle
ram_we  out  1  RAM write strobe
ram_wdata  out  8  RAM write data
ram_rdata  in  8  RAM read data, 1-cycle latency
tx_data  out  8  transmit byte (FIFO head)
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  sink accepts head when tx_valid & tx_ready
rx_data  in  8  receive byte
rx_valid  in  1  receive byte offered
rx_ready  out  1  receive holding register is empty

Behaviour:
- Reset clears:
  - address register = 0
  - read_pending = 0
  - FIFO count and pointers = 0
  - rx_hold_valid = 0
  - overflow = 0
- With no access in progress, all strobes are 0 and data_bus_out = 0.
- Address register: loads addr_bus_in on the rising edge with address_read = 1. Otherwise it holds. ram_addr is driven from it combinationally.
- mmio = (addr >= MMIO_BASE); the offset is addr[7:0].
- Read (the FSM asserts mem_enable & data_in for two consecutive cycles):
  - Cycle 1 (read_pending = 0): ram_re = !mmio. read_pending is set at the edge.
  - Cycle 2 (read_pending = 1): data_bus_oe = 1. data_bus_out = ram_rdata for RAM, or the MMIO value; read_pending clears at the edge.
- read_pending also clears in any cycle where mem_enable & data_in is 0. A lone cycle therefore produces no bus drive.
- A third consecutive data_in cycle restarts the sequence as a new cycle 1.
- MMIO read values, sampled in cycle 2:
  - Offset 0x00: 0.
  - Offset 0x01 (status): {4'b0, overflow, rx_hold_valid, fifo_empty, fifo_full}. overflow clears at the end of that cycle.
  - Offset 0x02: rx_hold byte; rx_hold_valid clears at the end of that cycle.
  - Other offsets: 8'h00.
- Write (mem_enable & data_out, single cycle):
  - RAM address: ram_we = 1, ram_wdata = data_bus_in, combinationally in the same cycle.
  - Offset 0x00: push data_bus_in into the FIFO. If the FIFO is full and not popping in that cycle, the byte is dropped and overflow is set (sticky).
  - Other MMIO offsets: writes ignored.
- data_in and data_out both asserted with mem_enable: no access at all (no strobes, no push), and read_pending clears.
- Transmit FIFO:
  - Pop on tx_valid & tx_ready.
  - Simultaneous push and pop while full: both take effect, count stays TX_DEPTH.
  - Simultaneous push and pop while empty: push only; tx_valid rises the next cycle.
  - Pointers wrap modulo TX_DEPTH; count width is $clog2(TX_DEPTH)+1.
- Receive:
  - rx_ready = !rx_hold_valid.
  - rx_valid & rx_ready captures rx_data and sets rx_hold_valid.
  - If a capture and a clearing read of offset 0x02 fall in the same cycle, the capture wins.
- Asynchronous reset mid-transfer aborts it: no write is completed afterwards, and oe drops immediately.

Decomposition:
- Shared package entries:
  - MMIO offset constants: MMIO_TX = 8'h00, MMIO_STATUS = 8'h01, MMIO_RX = 8'h02.
  - Status bit indices: STAT_FULL = 0, STAT_EMPTY = 1, STAT_RXV = 2, STAT_OVF = 3.
- One sub-module, tx_fifo (parameter DEPTH; push/pop/full/empty/head, async active-high rst).

Test Plan:
- RAM read: address_read with 16'h1234, then two data_in cycles, RAM model returns 8'hA5 → ram_re only in cycle 1, ram_addr = 16'h1234; data_bus_oe = 1 and data_bus_out = 8'hA5 only in cycle 2.
- RAM write: address 16'h0040, data_out with data_bus_in = 8'h3C → ram_we = 1 and ram_wdata = 8'h3C for exactly one cycle. Then write to 16'hFF05 → ram_we stays 0.
- FIFO fill with tx_ready = 0: push 8'h01..8'h05 to 16'hFF00 → tx_data = 8'h01 throughout, status read = 8'h09 (overflow + full), and a second status read = 8'h01.
- Drain and wrap: with tx_ready = 1, tx_data sequence is 01, 02, 03, 04; then status = 8'h02. Then push 8'h77 alongside a pop-on-full → count stays 4 and output order is preserved.
- RX: rx_valid with rx_data = 8'h5A → rx_ready falls. Read 16'hFF02 → bus = 8'h5A and rx_ready rises the next cycle. Re-offer during that read cycle → the new byte is held.
- Reset mid-read: assert rst between cycles 1 and 2 → data_bus_oe = 0 immediately, read_pending = 0, address register = 0.
